// File: rtl/shot_responder.sv
// Purpose : Battleship defending board: places ships, answers shots, tracks remaining ships.
// Latency : shot accepted in cycle N gives resp_valid in N+3; place_ok/place_err pulse one cycle after place_valid.
// Backpress: fire_ready low from acceptance until the response handshake; resp_valid/resp_code held until resp_ready.
//
// Ports:
//   clk, rst                     clock; synchronous active-high reset
//   clear                        synchronous board wipe, same effect as rst
//   place_valid/place_i/place_j  ship placement strobe and coordinates
//   place_ok/place_err           one-cycle placement result pulses
//   ships_placed                 ships currently on the board
//   fire_valid/fire_ready        shot request handshake, fire_i/fire_j coordinates
//   resp_valid/resp_ready        shot response handshake, resp_code 00 MISS 01 HIT 10 REPEAT 11 INVALID
//   ships_left, all_sunk         un-hit ship cells; sticky "every placed ship hit"
//   board_flat                   cell(i,j) at [2*(i*GRID+j)+:2]; 00 water 01 ship 10 miss 11 hit
// Optional build macro SHOT_RESPONDER_STATS_EN adds shots_total/hits_total saturating counters.
module shot_responder #(
    parameter int GRID      = 5,
    parameter int MAX_SHIPS = 5,
    parameter int COORD_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     place_valid,
    input  logic [COORD_W-1:0]       place_i,
    input  logic [COORD_W-1:0]       place_j,
    output logic                     place_ok,
    output logic                     place_err,
    output logic [2:0]               ships_placed,
    input  logic                     fire_valid,
    output logic                     fire_ready,
    input  logic [COORD_W-1:0]       fire_i,
    input  logic [COORD_W-1:0]       fire_j,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [1:0]               resp_code,
    output logic [2:0]               ships_left,
    output logic                     all_sunk,
    output logic [2*GRID*GRID-1:0]   board_flat
`ifdef SHOT_RESPONDER_STATS_EN
    ,
    output logic [7:0]               shots_total,
    output logic [7:0]               hits_total
`endif
);

    localparam int CELLS = GRID * GRID;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [1:0] CELL_WATER = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    localparam logic [1:0] CODE_MISS    = 2'b00;
    localparam logic [1:0] CODE_HIT     = 2'b01;
    localparam logic [1:0] CODE_REPEAT  = 2'b10;
    localparam logic [1:0] CODE_INVALID = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOOKUP  = 2'd1,
        S_UPDATE  = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           cells_q [CELLS];
    logic [1:0]           cells_d [CELLS];
    logic [COORD_W-1:0]   fi_q, fi_d, fj_q, fj_d;
    logic [1:0]           code_q, code_d;
    logic [2:0]           placed_q, placed_d;
    logic [2:0]           left_q, left_d;
    logic                 sunk_q, sunk_d;
    logic                 pok_q, pok_d;
    logic                 perr_q, perr_d;
`ifdef SHOT_RESPONDER_STATS_EN
    logic [7:0]           shots_q, shots_d;
    logic [7:0]           hits_q, hits_d;
`endif

    logic [IDX_W-1:0]     fire_idx, place_idx;
    logic                 fire_in_range, place_in_range;

    always_comb begin
        state_d    = state_q;
        cells_d    = cells_q;
        fi_d       = fi_q;
        fj_d       = fj_q;
        code_d     = code_q;
        placed_d   = placed_q;
        left_d     = left_q;
        pok_d      = 1'b0;
        perr_d     = 1'b0;
`ifdef SHOT_RESPONDER_STATS_EN
        shots_d    = shots_q;
        hits_d     = hits_q;
`endif
        fire_ready = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESPOND);

        // Linear index is only meaningful when both coordinates are in range;
        // every use is gated by the matching in_range flag.
        fire_in_range  = (int'(fi_q) < GRID) && (int'(fj_q) < GRID);
        place_in_range = (int'(place_i) < GRID) && (int'(place_j) < GRID);
        fire_idx       = IDX_W'(int'(fi_q) * GRID + int'(fj_q));
        place_idx      = IDX_W'(int'(place_i) * GRID + int'(place_j));

        case (state_q)
            S_IDLE: begin
                if (fire_valid) begin
                    fi_d    = fire_i;
                    fj_d    = fire_j;
                    state_d = S_LOOKUP;
                end
                // A shot accepted this cycle wins over a placement.
                if (place_valid) begin
                    if (!fire_valid && place_in_range
                        && (cells_q[place_idx] == CELL_WATER)
                        && (int'(placed_q) < MAX_SHIPS)) begin
                        cells_d[place_idx] = CELL_SHIP;
                        placed_d           = placed_q + 3'd1;
                        left_d             = left_q + 3'd1;
                        pok_d              = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            S_LOOKUP: begin
                if (!fire_in_range) begin
                    code_d = CODE_INVALID;
                end else begin
                    case (cells_q[fire_idx])
                        CELL_SHIP:  code_d = CODE_HIT;
                        CELL_WATER: code_d = CODE_MISS;
                        default:    code_d = CODE_REPEAT;
                    endcase
                end
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (code_q == CODE_HIT) begin
                    cells_d[fire_idx] = CELL_HIT;
                    if (left_q != 3'd0) left_d = left_q - 3'd1;
`ifdef SHOT_RESPONDER_STATS_EN
                    if (shots_q != 8'hFF) shots_d = shots_q + 8'd1;
                    if (hits_q != 8'hFF)  hits_d  = hits_q + 8'd1;
`endif
                end else if (code_q == CODE_MISS) begin
                    cells_d[fire_idx] = CELL_MISS;
`ifdef SHOT_RESPONDER_STATS_EN
                    if (shots_q != 8'hFF) shots_d = shots_q + 8'd1;
`endif
                end
                state_d = S_RESPOND;
            end
            S_RESPOND: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (place_valid && (state_q != S_IDLE)) perr_d = 1'b1;

        // Sticky: evaluated on next-state counts so it rises with the sinking response.
        sunk_d = sunk_q | ((placed_d != 3'd0) && (left_d == 3'd0));

        // clear behaves like reset and aborts any shot in flight.
        if (clear) begin
            state_d  = S_IDLE;
            for (int k = 0; k < CELLS; k++) cells_d[k] = CELL_WATER;
            fi_d     = '0;
            fj_d     = '0;
            code_d   = CODE_MISS;
            placed_d = 3'd0;
            left_d   = 3'd0;
            sunk_d   = 1'b0;
            pok_d    = 1'b0;
            perr_d   = 1'b0;
`ifdef SHOT_RESPONDER_STATS_EN
            shots_d  = 8'd0;
            hits_d   = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            for (int k = 0; k < CELLS; k++) cells_q[k] <= CELL_WATER;
            fi_q     <= '0;
            fj_q     <= '0;
            code_q   <= CODE_MISS;
            placed_q <= 3'd0;
            left_q   <= 3'd0;
            sunk_q   <= 1'b0;
            pok_q    <= 1'b0;
            perr_q   <= 1'b0;
`ifdef SHOT_RESPONDER_STATS_EN
            shots_q  <= 8'd0;
            hits_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            cells_q  <= cells_d;
            fi_q     <= fi_d;
            fj_q     <= fj_d;
            code_q   <= code_d;
            placed_q <= placed_d;
            left_q   <= left_d;
            sunk_q   <= sunk_d;
            pok_q    <= pok_d;
            perr_q   <= perr_d;
`ifdef SHOT_RESPONDER_STATS_EN
            shots_q  <= shots_d;
            hits_q   <= hits_d;
`endif
        end
    end

    always_comb begin
        board_flat = '0;
        for (int k = 0; k < CELLS; k++) board_flat[2*k +: 2] = cells_q[k];
    end

    assign place_ok     = pok_q;
    assign place_err    = perr_q;
    assign ships_placed = placed_q;
    assign ships_left   = left_q;
    assign all_sunk     = sunk_q;
    assign resp_code    = code_q;
`ifdef SHOT_RESPONDER_STATS_EN
    assign shots_total  = shots_q;
    assign hits_total   = hits_q;
`endif

endmodule

// File: tb/tb_shot_responder.sv
// Purpose : self-checking bench for shot_responder (directed scenarios then random place/fire/clear).
// Latency : checks resp_valid exactly three cycles after shot acceptance.
// Backpress: exercises resp_ready held low and verifies the response stays stable.
module tb_shot_responder;

    localparam int GRID = 5;
    localparam int MAXS = 5;
    localparam int CW   = 3;

    logic                   clk = 1'b0;
    logic                   rst, clear;
    logic                   place_valid;
    logic [CW-1:0]          place_i, place_j;
    logic                   place_ok, place_err;
    logic [2:0]             ships_placed;
    logic                   fire_valid, fire_ready;
    logic [CW-1:0]          fire_i, fire_j;
    logic                   resp_valid, resp_ready;
    logic [1:0]             resp_code;
    logic [2:0]             ships_left;
    logic                   all_sunk;
    logic [2*GRID*GRID-1:0] board_flat;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: board as a 2-D array of cell codes plus counters.
    int mb [GRID][GRID];
    int m_placed, m_left;
    int m_sunk;

    shot_responder #(.GRID(GRID), .MAX_SHIPS(MAXS), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .place_valid(place_valid), .place_i(place_i), .place_j(place_j),
        .place_ok(place_ok), .place_err(place_err), .ships_placed(ships_placed),
        .fire_valid(fire_valid), .fire_ready(fire_ready),
        .fire_i(fire_i), .fire_j(fire_j),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_code(resp_code),
        .ships_left(ships_left), .all_sunk(all_sunk), .board_flat(board_flat)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < GRID; i++)
            for (int j = 0; j < GRID; j++) mb[i][j] = 0;
        m_placed = 0;
        m_left   = 0;
        m_sunk   = 0;
    endfunction

    function automatic logic [63:0] model_flat();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < GRID; i++)
            for (int j = 0; j < GRID; j++) v[2*(i*GRID+j) +: 2] = 2'(mb[i][j]);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".ships_placed"}, ships_placed, m_placed);
        chk({tag, ".ships_left"}, ships_left, m_left);
        chk({tag, ".all_sunk"}, all_sunk, m_sunk);
        chk({tag, ".board"}, board_flat, model_flat());
    endtask

    // Starts and ends in an IDLE cycle, at posedge+1.
    task automatic do_place(input int i, input int j);
        int ok;
        ok = 0;
        if (i < GRID && j < GRID)
            if (mb[i][j] == 0 && m_placed < MAXS) ok = 1;
        place_valid = 1'b1;
        place_i     = CW'(i);
        place_j     = CW'(j);
        step();
        place_valid = 1'b0;
        chk("place_ok", place_ok, ok);
        chk("place_err", place_err, 1 - ok);
        if (ok == 1) begin
            mb[i][j] = 1;
            m_placed++;
            m_left++;
        end
        chk("place.ships_placed", ships_placed, m_placed);
        chk("place.ships_left", ships_left, m_left);
        chk("place.board", board_flat, model_flat());
    endtask

    // mode 0: plain shot; 1: placement alongside the shot; 2: placement during LOOKUP.
    task automatic do_fire(input int i, input int j, input int hold, input int mode);
        int exp_code;
        if (i >= GRID || j >= GRID)  exp_code = 3;
        else if (mb[i][j] >= 2)      exp_code = 2;
        else if (mb[i][j] == 1)      exp_code = 1;
        else                         exp_code = 0;

        chk("fire.ready_idle", fire_ready, 1);
        fire_valid = 1'b1;
        fire_i     = CW'(i);
        fire_j     = CW'(j);
        if (mode == 1) begin
            place_valid = 1'b1;
            place_i     = 1;
            place_j     = 1;
        end
        step();                                     // N+1
        fire_valid  = 1'b0;
        place_valid = 1'b0;
        if (mode == 1) begin
            chk("fire.place_same_cycle_err", place_err, 1);
            chk("fire.place_same_cycle_ok", place_ok, 0);
        end
        chk("fire.n1_resp_valid", resp_valid, 0);
        chk("fire.n1_ready", fire_ready, 0);
        if (mode == 2) begin
            place_valid = 1'b1;
            place_i     = 1;
            place_j     = 1;
        end
        step();                                     // N+2
        place_valid = 1'b0;
        if (mode == 2) begin
            chk("fire.place_busy_err", place_err, 1);
            chk("fire.place_busy_ok", place_ok, 0);
        end
        chk("fire.n2_resp_valid", resp_valid, 0);
        step();                                     // N+3
        if (exp_code == 1) begin
            mb[i][j] = 3;
            if (m_left > 0) m_left--;
        end else if (exp_code == 0) begin
            mb[i][j] = 2;
        end
        if (m_placed != 0 && m_left == 0) m_sunk = 1;
        chk("fire.n3_resp_valid", resp_valid, 1);
        chk("fire.resp_code", resp_code, exp_code);
        check_state("fire");
        for (int k = 0; k < hold; k++) begin
            step();
            chk("hold.resp_valid", resp_valid, 1);
            chk("hold.resp_code", resp_code, exp_code);
            chk("hold.fire_ready", fire_ready, 0);
        end
        resp_ready = 1'b1;
        step();                                     // back in IDLE
        resp_ready = 1'b0;
        chk("fire.done_resp_valid", resp_valid, 0);
        chk("fire.done_ready", fire_ready, 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
        check_state("clear");
        chk("clear.resp_code", resp_code, 0);
        chk("clear.resp_valid", resp_valid, 0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        place_valid = 1'b0; place_i = '0; place_j = '0;
        fire_valid = 1'b0; fire_i = '0; fire_j = '0;
        resp_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state("reset");
        chk("reset.fire_ready", fire_ready, 1);
        chk("reset.resp_valid", resp_valid, 0);
        chk("reset.resp_code", resp_code, 0);
        chk("reset.place_ok", place_ok, 0);
        chk("reset.place_err", place_err, 0);

        // Directed scenario
        do_place(0, 0);
        do_place(2, 3);
        do_place(0, 0);                 // occupied -> error
        do_place(5, 1);                 // off board -> error
        do_fire(2, 3, 0, 0);            // hit
        do_fire(2, 3, 0, 0);            // repeat
        do_fire(4, 4, 0, 0);            // miss
        do_fire(5, 1, 0, 0);            // invalid
        do_fire(0, 0, 10, 0);           // last ship, held response
        chk("directed.all_sunk", all_sunk, 1);
        do_clear();

        // Ship limit
        do_place(0, 1); do_place(1, 2); do_place(2, 2); do_place(3, 3); do_place(4, 0);
        do_place(4, 4);                 // sixth ship -> error
        do_clear();

        // Placement conflicts with shots
        do_place(0, 1);
        do_fire(0, 1, 0, 1);
        do_fire(3, 3, 1, 2);

        // clear while the shot is in LOOKUP
        fire_valid = 1'b1; fire_i = 2; fire_j = 2;
        step();
        fire_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
        chk("abort.resp_valid_a", resp_valid, 0);
        step();
        chk("abort.fire_ready", fire_ready, 1);
        chk("abort.resp_valid_b", resp_valid, 0);
        check_state("abort");
        step();
        chk("abort.resp_valid_c", resp_valid, 0);

        // Random phase
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) do_clear();
            else if (r < 8) do_place($urandom_range(0, GRID), $urandom_range(0, GRID));
            else do_fire($urandom_range(0, GRID), $urandom_range(0, GRID),
                         $urandom_range(0, 2), 0);
        end
        check_state("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
